uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single UART transmitter between `NUM_REQ` byte-stream requesters on the system bus side. It grants the transmitter to one requester per packet, meaning a run of bytes ending in a byte flagged `last`. It sequences every byte through the transmitter's `data_en`/`tx_busy` handshake and holds the grant for the whole packet. It sits between the bus-side masters/slaves and the `data_input`/`data_en`/`tx_busy` pins of the UART wrapper.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the packet arbiter and the UART TX pins.
// Latency: none (wires only).
// Backpressure: requesters hold req_valid/req_data/req_last until req_ack; the UART throttles via tx_busy.
//
// Signals:
//   req_valid/req_data/req_last : per-requester byte offer, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack                     : one-cycle consume pulse back to the requester
//   grant                       : one-hot packet owner, zero when idle
//   tx_data/tx_start/tx_busy    : UART data_input / data_en / tx_busy
//   arb_busy/err_timeout        : packet in progress / packet aborted
// Modports: slave = the arbiter, master = the requester + UART side driving it.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_start;
  logic                          tx_busy;
  logic                          arb_busy;
  logic                          err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ack, grant, tx_data, tx_start, arb_busy, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ack, grant, tx_data, tx_start, arb_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Latency: req_valid sampled in IDLE -> tx_start/req_ack/grant one cycle later.
// Backpressure: each byte waits for tx_busy to rise then fall; the owner keeps the grant until its last byte.
//
// Ports: clk, rst (synchronous, active high), bus (uart_tx_arbiter_if.slave).
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a packet when tx_busy never rises
// within BUSY_TIMEOUT cycles of tx_start (err_timeout pulses, grant released, rr advanced).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16384
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, NEXT} state_t;

  state_t                state;
  logic [IW-1:0]         rr;
  logic [IW-1:0]         owner;
  logic                  last_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  start_q;
  logic                  busy_q;

  logic                  win_vld;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         sel;
  logic [DATA_WIDTH-1:0] load_dat;
  logic                  load_last;
  logic [IW-1:0]         rr_after;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;
`else
  // BUSY_TIMEOUT only sizes the abort counter; keep it referenced in this build.
  logic unused_busy_timeout;
  assign unused_busy_timeout = (BUSY_TIMEOUT > 0);
`endif

  // Round robin: first valid requester scanning upward from rr with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr) + k) % NUM_REQ);
      if (!win_vld && bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // In IDLE the byte comes from the fresh winner, later bytes from the locked owner.
  always_comb begin
    sel      = (state == IDLE) ? win_idx : owner;
    load_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IW'(k)) load_dat = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    load_last = bus.req_last[sel];
  end

  assign rr_after = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= '0;
      owner   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!bus.tx_busy && win_vld) begin
            owner   <= win_idx;
            grant_q <= NUM_REQ'(1) << win_idx;
            data_q  <= load_dat;
            last_q  <= load_last;
            start_q <= 1'b1;
            ack_q   <= NUM_REQ'(1) << win_idx;
            busy_q  <= 1'b1;
            state   <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (to_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            // UART never acknowledged the byte: drop the rest of the packet.
            err_q   <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr      <= rr_after;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              rr      <= rr_after;
              state   <= IDLE;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          // Grant stays locked; other requesters wait however long the owner stalls.
          if (bus.req_valid[owner]) begin
            data_q  <= load_dat;
            last_q  <= load_last;
            start_q <= 1'b1;
            ack_q   <= NUM_REQ'(1) << owner;
            state   <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.req_ack  = ack_q;
  assign bus.tx_data  = data_q;
  assign bus.tx_start = start_q;
  assign bus.arb_busy = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner sequences,
// then randomized traffic against a packet-level reference model.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int DW = 8;
  localparam int TO = 20;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ack0 = 0;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] q_data[NR][$];
  bit         q_last[NR][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Outputs are observed and inputs driven at the falling edge.
  task automatic step();
    @(negedge clk);
    if (bus.tx_start) n_start++;
    if (bus.req_ack[0]) n_ack0++;
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.tx_start && n < budget) begin
      step();
      n++;
    end
    chk(name, bus.tx_start, 1);
  endtask

  // UART accepts the byte: busy rises, holds two cycles, falls.
  task automatic busy_cycle();
    bus.tx_busy = 1'b1;
    step();
    step();
    bus.tx_busy = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.tx_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int m_owner;
    int rr_m;
    bit m_rel;
    int w;
    int exp_w;
    int ut_phase;
    int ut_cnt;
    bit pres[NR];
    bit done;
    logic [NR-1:0] pv;
    logic pb;

    // rr evolution: 0 ->(A1) 1 ->(B2) 0 ->(C3) 1 ->(D5) 0 ->(5A) 1 ->(6B) 1 ->(E7) 0 ->(3C) 0 ->(0F)
    vecs[0] = '{2'b11, 8'hA1, 8'hB2, 2'b01, 8'hA1};
    vecs[1] = '{2'b11, 8'h77, 8'hB2, 2'b10, 8'hB2};
    vecs[2] = '{2'b11, 8'hC3, 8'hD4, 2'b01, 8'hC3};
    vecs[3] = '{2'b11, 8'hC4, 8'hD5, 2'b10, 8'hD5};
    vecs[4] = '{2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A};
    vecs[5] = '{2'b01, 8'h6B, 8'h00, 2'b01, 8'h6B};
    vecs[6] = '{2'b10, 8'h00, 8'hE7, 2'b10, 8'hE7};
    vecs[7] = '{2'b10, 8'h00, 8'h3C, 2'b10, 8'h3C};
    vecs[8] = '{2'b11, 8'h0F, 8'hF0, 2'b01, 8'h0F};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_busy = 1'b0;
    repeat (3) step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_arb_busy", bus.arb_busy, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst = 1'b0;
    step();

    // ---- table vectors: single-byte packets, round robin ----
    for (int v = 0; v < 9; v++) begin
      bus.req_valid = vecs[v].valid;
      bus.req_data = {vecs[v].d1, vecs[v].d0};
      bus.req_last = 2'b11;
      step();
      chk("vec_start", bus.tx_start, 1);
      chk("vec_grant", bus.grant, vecs[v].exp_grant);
      chk("vec_ack", bus.req_ack, vecs[v].exp_grant);
      chk("vec_data", bus.tx_data, vecs[v].exp_data);
      chk("vec_arb_busy", bus.arb_busy, 1);
      bus.req_valid = '0;
      bus.tx_busy = 1'b1;
      step();
      chk("vec_pulse_low", {bus.tx_start, bus.req_ack}, 0);
      chk("vec_data_hold", bus.tx_data, vecs[v].exp_data);
      step();
      bus.tx_busy = 1'b0;
      step();
      chk("vec_release", bus.grant, 0);
      chk("vec_idle", bus.arb_busy, 0);
    end

    // ---- packet lock: req0 sends 10,11,12 while req1 holds 99 ----
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_data = {8'h99, 8'h10};
    bus.req_last = 2'b10;
    n_ack0 = 0;
    for (int b = 0; b < 3; b++) begin
      wait_start("lock_start", 10);
      chk("lock_grant", bus.grant, 2'b01);
      chk("lock_data", bus.tx_data, 8'h10 + b);
      if (b < 2) begin
        bus.req_data[7:0] = 8'(8'h11 + b);
        bus.req_last[0] = (b == 1);
      end else begin
        bus.req_valid[0] = 1'b0;
      end
      busy_cycle();
    end
    chk("lock_ack_count", n_ack0, 3);
    wait_start("lock_next", 10);
    chk("lock_next_grant", bus.grant, 2'b10);
    chk("lock_next_data", bus.tx_data, 8'h99);
    bus.req_valid = '0;
    busy_cycle();

    // ---- owner stall: req0 idles 50 cycles mid-packet, req1 waiting ----
    bus.req_valid = 2'b11;
    bus.req_data = {8'h88, 8'h20};
    bus.req_last = 2'b10;
    wait_start("stall_first", 10);
    chk("stall_first_grant", bus.grant, 2'b01);
    chk("stall_first_data", bus.tx_data, 8'h20);
    bus.req_valid[0] = 1'b0;
    busy_cycle();
    n_start = 0;
    repeat (50) step();
    chk("stall_no_start", n_start, 0);
    chk("stall_grant", bus.grant, 2'b01);
    chk("stall_arb_busy", bus.arb_busy, 1);
    bus.req_valid[0] = 1'b1;
    bus.req_data[7:0] = 8'h21;
    bus.req_last[0] = 1'b1;
    wait_start("stall_resume", 10);
    chk("stall_resume_grant", bus.grant, 2'b01);
    chk("stall_resume_data", bus.tx_data, 8'h21);
    bus.req_valid[0] = 1'b0;
    busy_cycle();
    wait_start("stall_other", 10);
    chk("stall_other_grant", bus.grant, 2'b10);
    chk("stall_other_data", bus.tx_data, 8'h88);
    bus.req_valid = '0;
    busy_cycle();

    // ---- reset mid-packet: rr is 1 before reset, 0 after ----
    bus.req_valid = 2'b01;
    bus.req_data[7:0] = 8'h30;
    bus.req_last = 2'b01;
    wait_start("mid_pre", 10);
    chk("mid_pre_data", bus.tx_data, 8'h30);
    bus.req_valid = '0;
    busy_cycle();
    bus.req_valid = 2'b10;
    bus.req_data[15:8] = 8'h41;
    bus.req_last = 2'b00;
    wait_start("mid_start", 10);
    chk("mid_grant", bus.grant, 2'b10);
    bus.tx_busy = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_ack", bus.req_ack, 0);
    chk("mid_rst_start", bus.tx_start, 0);
    chk("mid_rst_data", bus.tx_data, 0);
    chk("mid_rst_arb_busy", bus.arb_busy, 0);
    chk("mid_rst_err", bus.err_timeout, 0);
    rst = 1'b0;
    bus.tx_busy = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data = {8'h51, 8'h50};
    bus.req_last = 2'b11;
    wait_start("mid_after", 10);
    chk("mid_after_grant", bus.grant, 2'b01);
    chk("mid_after_data", bus.tx_data, 8'h50);
    bus.req_valid = '0;
    busy_cycle();

    // ---- busy never rises ----
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_data[7:0] = 8'h60;
    bus.req_last = 2'b11;
    wait_start("to_start", 10);
    bus.req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!bus.err_timeout && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_grant", bus.grant, 0);
    chk("to_arb_busy", bus.arb_busy, 0);
    step();
    chk("to_pulse_low", bus.err_timeout, 0);
    bus.req_valid = 2'b11;
    bus.req_data = {8'h62, 8'h61};
    wait_start("to_next", 10);
    chk("to_next_grant", bus.grant, 2'b10);
    bus.req_valid = '0;
    busy_cycle();
`else
    repeat (40) step();
    chk("noto_err", bus.err_timeout, 0);
    chk("noto_grant", bus.grant, 2'b01);
    chk("noto_arb_busy", bus.arb_busy, 1);
    busy_cycle();
    chk("noto_release", bus.grant, 0);
`endif

    // ---- randomized traffic vs packet-level model ----
    do_reset();
    for (int i = 0; i < NR; i++) begin
      int seq;
      seq = 0;
      for (int p = 0; p < 12; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          q_data[i].push_back(8'(i * 128 + seq));
          q_last[i].push_back(b == len - 1);
          seq++;
        end
      end
      pres[i] = 1'b0;
    end
    m_owner = -1;
    rr_m = 0;
    m_rel = 1'b0;
    ut_phase = 0;
    ut_cnt = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      pv = bus.req_valid;
      pb = bus.tx_busy;
      step();
      chk("rnd_arb_busy", bus.arb_busy, |bus.grant);
      if (m_owner >= 0 && bus.grant == 0) begin
        chk("rnd_release_after_last", m_rel, 1);
        rr_m = (m_owner + 1) % NR;
        m_owner = -1;
        m_rel = 1'b0;
      end
      if (bus.tx_start) begin
        chk("rnd_start_busy", pb, 0);
        chk("rnd_start_overlap", ut_phase == 1, 0);
        chk("rnd_ack_grant", bus.req_ack, bus.grant);
        chk("rnd_ack_onehot", $countones(bus.req_ack), 1);
        w = bus.req_ack[1] ? 1 : 0;
        if (m_owner < 0) begin
          exp_w = -1;
          for (int k = 0; k < NR; k++) begin
            if (exp_w < 0 && pv[(rr_m + k) % NR]) exp_w = (rr_m + k) % NR;
          end
          chk("rnd_winner", w, exp_w);
          m_owner = w;
        end else begin
          chk("rnd_owner_hold", w, m_owner);
        end
        chk("rnd_valid_at_load", pv[w], 1);
        chk("rnd_byte_avail", q_data[w].size() > 0, 1);
        if (q_data[w].size() > 0) begin
          chk("rnd_byte", bus.tx_data, q_data[w][0]);
          m_rel = q_last[w][0];
          void'(q_data[w].pop_front());
          void'(q_last[w].pop_front());
        end
        pres[w] = 1'b0;
        bus.req_valid[w] = 1'b0;
        ut_phase = 1;
        ut_cnt = $urandom_range(0, 2);
      end
      // UART model; occasional busy while idle exercises the IDLE gate.
      if (ut_phase == 1) begin
        if (ut_cnt == 0) begin
          bus.tx_busy = 1'b1;
          ut_phase = 2;
          ut_cnt = $urandom_range(1, 5);
        end else begin
          ut_cnt--;
        end
      end else if (ut_phase == 2) begin
        if (ut_cnt == 0) begin
          bus.tx_busy = 1'b0;
          ut_phase = 0;
        end else begin
          ut_cnt--;
        end
      end else if (bus.grant == 0 && $urandom_range(0, 15) == 0) begin
        bus.tx_busy = 1'b1;
        ut_phase = 2;
        ut_cnt = $urandom_range(1, 3);
      end
      for (int i = 0; i < NR; i++) begin
        if (!pres[i] && q_data[i].size() > 0 && $urandom_range(0, 2) == 0) begin
          pres[i] = 1'b1;
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*DW +: DW] = q_data[i][0];
          bus.req_last[i] = q_last[i][0];
        end
      end
      done = (q_data[0].size() == 0) && (q_data[1].size() == 0) && (m_owner < 0) &&
             (bus.grant == 0) && (ut_phase == 0);
    end
    chk("rnd_drained0", q_data[0].size(), 0);
    chk("rnd_drained1", q_data[1].size(), 0);
    chk("rnd_finished", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
